// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [3:0]  MASK_WORD = 4'hF;
    localparam logic        MEM_READ  = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Circular instruction buffer holding {pc, instr} entries between fetch and decode.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter  int BUF_DEPTH = 2,
    localparam int PTR_W     = $clog2(BUF_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);
    fetch_entry_t     mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_entry;
    end

    // Storage is not reset, so gate the head to keep outputs at zero when empty.
    assign head = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC generation, instruction-memory requests, response buffering, redirect flush.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ADDR_W    = 8,
    parameter int          BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_en,
    input  logic [31:0]       redirect_pc,
    output logic              imem_request,
    output logic              imem_we_re,
    output logic [3:0]        imem_mask,
    output logic [ADDR_W-1:0] imem_address,
    output logic [31:0]       imem_data_in,
    input  logic              imem_valid,
    input  logic [31:0]       imem_data_out,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_out,
    output logic [31:0]       inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubble,
    output logic [15:0]       perf_flush
`endif
);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [31:0]      pc_q, req_pc_q, issue_pc, redirect_tgt;
    logic             inflight_q, push, pop;
    logic [CNT_W-1:0] count, count_next;
    fetch_entry_t     head, push_entry;
    logic             unused_ok;

    assign unused_ok    = &{1'b0, redirect_pc[1:0]};
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign issue_pc     = redirect_en ? redirect_tgt : pc_q;

    // A redirect kills the old-path response arriving this cycle.
    assign push       = inflight_q & imem_valid & ~redirect_en;
    assign push_entry = '{pc: req_pc_q, instr: imem_data_out};
    assign inst_valid = (count != '0) & ~redirect_en;
    assign pop        = inst_valid & inst_ready;
    assign count_next = redirect_en ? '0 : count + CNT_W'(push) - CNT_W'(pop);

    // Only request when next cycle's response is guaranteed a free slot.
    assign imem_request = rst & (count_next < CNT_W'(BUF_DEPTH));
    assign imem_address = issue_pc[ADDR_W+1:2];
    assign imem_we_re   = MEM_READ;
    assign imem_mask    = MASK_WORD;
    assign imem_data_in = '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= imem_request;
            if (imem_request) begin
                req_pc_q <= issue_pc;
                pc_q     <= issue_pc + 32'd4;
            end else if (redirect_en) begin
                pc_q <= redirect_tgt;
            end
        end
    end

    fetch_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_en),
        .count      (count),
        .head       (head)
    );

    assign inst_out = head.instr;
    assign inst_pc  = head.pc;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_bubble  <= '0;
            perf_flush   <= '0;
        end else begin
            if (pop && perf_fetched != '1) perf_fetched <= perf_fetched + 1'b1;
            if (!inst_valid && inst_ready && perf_bubble != '1) perf_bubble <= perf_bubble + 1'b1;
            if (redirect_en && perf_flush != '1) perf_flush <= perf_flush + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: instruction memory model, in-order scoreboard, directed sequences.
module tb_fetch_unit;
    logic        clk, rst, redirect_en, imem_request, imem_we_re, imem_valid;
    logic        inst_valid, inst_ready, inject;
    logic [31:0] redirect_pc, imem_data_in, imem_data_out, inst_out, inst_pc;
    logic [3:0]  imem_mask;
    logic [7:0]  imem_address;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_bubble;
    logic [15:0] perf_flush;
    int          m_fetched, m_bubble, m_flush;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic        req;
        logic [7:0]  addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] out;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t tbl[5];
    int   checks = 0;
    int   errors = 0;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc),
        .imem_request  (imem_request),
        .imem_we_re    (imem_we_re),
        .imem_mask     (imem_mask),
        .imem_address  (imem_address),
        .imem_data_in  (imem_data_in),
        .imem_valid    (imem_valid),
        .imem_data_out (imem_data_out),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_bubble   (perf_bubble),
        .perf_flush    (perf_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: word n holds 0x1000_0000+n; inject forces a bogus response.
    always @(posedge clk) begin
        imem_valid    <= imem_request | inject;
        imem_data_out <= inject ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(imem_address);
    end

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'h1000_0000 + {24'h0, pc[9:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic new_stream(input logic [31:0] pc);
        exp_t x;
        sb.delete();
        for (int i = 0; i < 64; i++) begin
            x.pc    = pc + 32'(4 * i);
            x.instr = word_at(x.pc);
            sb.push_back(x);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every accepted instruction must be the next one in program order.
    always @(negedge clk) begin
        if (rst && inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got pc %h expected none", inst_pc);
            end else begin
                e = sb.pop_front();
                chk("pop_pc", inst_pc, e.pc);
                chk("pop_instr", inst_out, e.instr);
            end
        end
`ifdef FETCH_PERF_EN
        if (!rst) begin
            m_fetched = 0; m_bubble = 0; m_flush = 0;
        end else begin
            if (inst_valid && inst_ready) m_fetched++;
            if (!inst_valid && inst_ready) m_bubble++;
            if (redirect_en) m_flush++;
        end
`endif
    end

    task automatic redirect_test(input logic [31:0] tgt, input logic [7:0] addr);
        logic [31:0] base;
        logic [7:0]  nxt;
        base = {tgt[31:2], 2'b00};
        nxt  = addr + 8'd1;
        redirect_en = 1'b1;
        redirect_pc = tgt;
        new_stream(base);
        @(negedge clk);
        chk("redir_req", imem_request, 1);
        chk("redir_addr", imem_address, addr);
        chk("redir_vld", inst_valid, 0);
        step();
        redirect_en = 1'b0;
        @(negedge clk);
        chk("redir1_vld", inst_valid, 0);
        chk("redir1_addr", imem_address, nxt);
        step();
        @(negedge clk);
        chk("redir2_vld", inst_valid, 1);
        chk("redir2_pc", inst_pc, base);
        chk("redir2_out", inst_out, word_at(base));
        step();
    endtask

    initial begin
        tbl[0] = '{req: 1'b1, addr: 8'd0, vld: 1'b0, pc: 32'h0, out: 32'h0};
        tbl[1] = '{req: 1'b1, addr: 8'd1, vld: 1'b0, pc: 32'h0, out: 32'h0};
        tbl[2] = '{req: 1'b1, addr: 8'd2, vld: 1'b1, pc: 32'h0, out: 32'h1000_0000};
        tbl[3] = '{req: 1'b1, addr: 8'd3, vld: 1'b1, pc: 32'h4, out: 32'h1000_0001};
        tbl[4] = '{req: 1'b1, addr: 8'd4, vld: 1'b1, pc: 32'h8, out: 32'h1000_0002};

        rst = 1'b0; redirect_en = 1'b0; redirect_pc = '0; inst_ready = 1'b1; inject = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", imem_request, 0);
        chk("rst_vld", inst_valid, 0);
        chk("rst_out", inst_out, 0);
        chk("rst_pc", inst_pc, 0);
        chk("we_re", imem_we_re, 0);
        chk("mask", imem_mask, 4'hF);
        chk("data_in", imem_data_in, 0);

        step();
        new_stream(32'h0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("tbl_req", imem_request, tbl[i].req);
            chk("tbl_addr", imem_address, tbl[i].addr);
            chk("tbl_vld", inst_valid, tbl[i].vld);
            if (tbl[i].vld) begin
                chk("tbl_pc", inst_pc, tbl[i].pc);
                chk("tbl_out", inst_out, tbl[i].out);
            end
            step();
        end
        repeat (3) step();

        // Back-pressure: buffer fills, requests stop, stream resumes intact.
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_req", imem_request, 0);
            chk("stall_vld", inst_valid, 1);
            step();
        end
        inst_ready = 1'b1;
        repeat (6) step();

        redirect_test(32'h40, 8'h10);
        repeat (3) step();
        redirect_test(32'h43, 8'h10);
        repeat (3) step();
        redirect_test(32'h3FC, 8'hFF);
        repeat (3) step();

        // Reset mid-stream with a bogus response landing after release.
        rst = 1'b0;
        inject = 1'b1;
        #1;
        chk("mrst_req", imem_request, 0);
        chk("mrst_vld", inst_valid, 0);
        chk("mrst_out", inst_out, 0);
        chk("mrst_pc", inst_pc, 0);
        new_stream(32'h0);
        step();
        inject = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst0_addr", imem_address, 0);
        chk("mrst0_vld", inst_valid, 0);
        step();
        @(negedge clk);
        chk("mrst1_vld", inst_valid, 0);
        step();
        @(negedge clk);
        chk("mrst2_vld", inst_valid, 1);
        chk("mrst2_pc", inst_pc, 0);
        chk("mrst2_out", inst_out, 32'h1000_0000);
        repeat (4) step();

        inst_ready = 1'b0;
        step();
`ifdef FETCH_PERF_EN
        @(negedge clk);
        chk("perf_fetched", perf_fetched, 32'(m_fetched));
        chk("perf_bubble", perf_bubble, 32'(m_bubble));
        chk("perf_flush", {16'h0, perf_flush}, 32'(m_flush));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
